// File: rtl/nco_pkg.sv
// nco_pkg: shared types and constants for the voice scheduler.
//   sample_t - signed 16-bit audio sample
//   phase_t  - 32-bit NCO phase accumulator value
//   state_e  - scheduler FSM states
//   SAT_MAX / SAT_MIN - clamp limits of the 16-bit mix output
package nco_pkg;

  typedef logic signed [15:0] sample_t;
  typedef logic [31:0]        phase_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ISSUE,
    S_WAIT,
    S_MIX,
    S_OUTPUT
  } state_e;

  localparam sample_t SAT_MAX = 16'sh7FFF;
  localparam sample_t SAT_MIN = 16'sh8000;

endpackage

// File: rtl/voice_phase_bank.sv
// voice_phase_bank: per-voice 32-bit phase registers.
//   master_clk      - clock (rising edge)
//   rst             - synchronous active-low reset, clears every phase
//   rd_idx          - voice selected for read / update
//   adv_en          - phase[rd_idx] += increment[rd_idx] (mod 2^32)
//   clr_en          - phase[rd_idx] <= 0 (muted voice); wins over adv_en
//   voice_increment - packed per-voice increments, voice v at [32v+31:32v]
//   rd_phase        - current phase of voice rd_idx
module voice_phase_bank
  import nco_pkg::*;
#(
  parameter int NUM_VOICES = 4
) (
  input  logic                          master_clk,
  input  logic                          rst,
  input  logic [$clog2(NUM_VOICES)-1:0] rd_idx,
  input  logic                          adv_en,
  input  logic                          clr_en,
  input  logic [32*NUM_VOICES-1:0]      voice_increment,
  output phase_t                        rd_phase
);

  localparam int IDX_W = $clog2(NUM_VOICES);

  phase_t phase_rd [NUM_VOICES];

  for (genvar gv = 0; gv < NUM_VOICES; gv++) begin : g_voice
    phase_t phase_q;

    always_ff @(posedge master_clk) begin
      if (!rst) begin
        phase_q <= '0;
      end else if (rd_idx == IDX_W'(gv)) begin
        if (clr_en)      phase_q <= '0;
        // Wrap-around is intentional: the phase is a modulo-2^32 NCO.
        else if (adv_en) phase_q <= phase_q + voice_increment[32*gv +: 32];
      end
    end

    assign phase_rd[gv] = phase_q;
  end

  assign rd_phase = phase_rd[rd_idx];

endmodule

// File: rtl/voice_scheduler.sv
// voice_scheduler: time-multiplexes NUM_VOICES voices onto one shared NCO
// datapath once per sample tick and mixes the results.
//   master_clk      - clock (rising edge)
//   rst             - synchronous active-low reset
//   sample_clk_en   - one-cycle sample tick; ignored (and flagged) while busy
//   voice_increment - per-voice phase increments
//   voice_mute      - per-voice mute; muted voices have their phase cleared
//   dp_start/dp_phase/dp_done/dp_sample - shared datapath handshake
//   mix_output/mix_valid - saturated mix and its one-cycle strobe
//   busy            - frame in progress (tick accepted .. mix_valid)
//   overrun         - sticky: a tick arrived while busy
module voice_scheduler
  import nco_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int MIX_SHIFT  = 2
) (
  input  logic                     master_clk,
  input  logic                     rst,
  input  logic                     sample_clk_en,
  input  logic [32*NUM_VOICES-1:0] voice_increment,
  input  logic [NUM_VOICES-1:0]    voice_mute,
  output logic                     dp_start,
  output phase_t                   dp_phase,
  input  logic                     dp_done,
  input  sample_t                  dp_sample,
  output sample_t                  mix_output,
  output logic                     mix_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  // One guard bit above the worst-case sum so the accumulator never wraps.
  localparam int ACC_W = 16 + IDX_W + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(SAT_MIN);

  state_e                  state_q, state_d;
  logic [IDX_W:0]          idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  sample_t                 samp_q, samp_d;
  phase_t                  dp_phase_q, dp_phase_d;
  sample_t                 mix_q, mix_d;
  logic                    overrun_q, overrun_d;

  logic [IDX_W-1:0]        vidx;
  logic                    last_voice;
  logic                    bank_adv, bank_clr;
  phase_t                  rd_phase;
  logic signed [ACC_W-1:0] acc_shr;
  sample_t                 sat_val;

  assign vidx       = idx_q[IDX_W-1:0];
  assign last_voice = (idx_q == (IDX_W+1)'(NUM_VOICES));

  voice_phase_bank #(.NUM_VOICES(NUM_VOICES)) u_bank (
    .master_clk      (master_clk),
    .rst             (rst),
    .rd_idx          (vidx),
    .adv_en          (bank_adv),
    .clr_en          (bank_clr),
    .voice_increment (voice_increment),
    .rd_phase        (rd_phase)
  );

  assign acc_shr = acc_q >>> MIX_SHIFT;

  always_comb begin
    if (acc_shr > ACC_MAX)      sat_val = SAT_MAX;
    else if (acc_shr < ACC_MIN) sat_val = SAT_MIN;
    else                        sat_val = acc_shr[15:0];
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    samp_d     = samp_q;
    dp_phase_d = dp_phase_q;
    mix_d      = mix_q;
    bank_adv   = 1'b0;
    bank_clr   = 1'b0;
    overrun_d  = overrun_q | (sample_clk_en & (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (sample_clk_en) begin
          state_d = S_SELECT;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      S_SELECT: begin
        if (last_voice) begin
          // Load the result on the way into OUTPUT so it is stable while
          // mix_valid is high.
          mix_d   = sat_val;
          state_d = S_OUTPUT;
        end else if (voice_mute[vidx]) begin
          bank_clr = 1'b1;
          idx_d    = idx_q + 1'b1;
        end else begin
          dp_phase_d = rd_phase;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bank_adv = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (dp_done) begin
          samp_d  = dp_sample;
          state_d = S_MIX;
        end
      end
      S_MIX: begin
        acc_d   = acc_q + ACC_W'(samp_q);
        idx_d   = idx_q + 1'b1;
        state_d = S_SELECT;
      end
      S_OUTPUT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge master_clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      samp_q     <= '0;
      dp_phase_q <= '0;
      mix_q      <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      samp_q     <= samp_d;
      dp_phase_q <= dp_phase_d;
      mix_q      <= mix_d;
      overrun_q  <= overrun_d;
    end
  end

  assign dp_start   = (state_q == S_ISSUE);
  assign dp_phase   = dp_phase_q;
  assign mix_output = mix_q;
  assign mix_valid  = (state_q == S_OUTPUT);
  assign busy       = (state_q != S_IDLE);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_voice_scheduler.sv
module tb_voice_scheduler;
  import nco_pkg::*;

  localparam int NV = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic [32*NV-1:0] inc = '0;
  logic [NV-1:0] mute = '0;
  logic          dp_done_m = 1'b0, stray_done = 1'b0, dp_done;
  sample_t       dp_sample = '0;
  logic          dp_start, dp_start_s;
  phase_t        dp_phase, dp_phase_s;
  sample_t       mix, mix_s;
  logic          mix_valid, mix_valid_s, busy, busy_s, overrun, overrun_s;

  assign dp_done = dp_done_m | stray_done;

  always #5 clk = ~clk;

  // Main instance (MIX_SHIFT=2) drives the datapath model; the MIX_SHIFT=0
  // instance sees identical inputs and runs in lock-step, exposing saturation.
  voice_scheduler #(.NUM_VOICES(NV), .MIX_SHIFT(2)) u_dut (
    .master_clk(clk), .rst(rst_n), .sample_clk_en(tick),
    .voice_increment(inc), .voice_mute(mute),
    .dp_start(dp_start), .dp_phase(dp_phase), .dp_done(dp_done), .dp_sample(dp_sample),
    .mix_output(mix), .mix_valid(mix_valid), .busy(busy), .overrun(overrun)
  );

  voice_scheduler #(.NUM_VOICES(NV), .MIX_SHIFT(0)) u_sat (
    .master_clk(clk), .rst(rst_n), .sample_clk_en(tick),
    .voice_increment(inc), .voice_mute(mute),
    .dp_start(dp_start_s), .dp_phase(dp_phase_s), .dp_done(dp_done), .dp_sample(dp_sample),
    .mix_output(mix_s), .mix_valid(mix_valid_s), .busy(busy_s), .overrun(overrun_s)
  );

  int n_tests = 0, n_fail = 0;
  int nvalid = 0, nstart = 0;
  int dp_lat = 1;
  bit echo = 1'b0;
  logic [15:0] csamp = '0;
  logic [31:0] plog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Datapath model: answers every dp_start after dp_lat cycles.
  initial begin
    logic [31:0] ph;
    forever begin
      @(negedge clk);
      dp_done_m = 1'b0;
      if (dp_start) begin
        ph = dp_phase;
        plog.push_back(ph);
        nstart++;
        repeat (dp_lat) @(negedge clk);
        if (busy) chk("dp_phase_hold", dp_phase, ph);
        dp_sample = echo ? sample_t'(ph[31:16]) : sample_t'(csamp);
        dp_done_m = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (mix_valid) nvalid++;
  end

  // Issue one tick and wait (bounded) for mix_valid; returns latency in cycles.
  task automatic frame(output int cyc, output logic [15:0] m, output logic [15:0] ms);
    cyc = 0;
    @(negedge clk); tick = 1'b1;
    do begin
      @(negedge clk); tick = 1'b0; cyc++;
    end while (!mix_valid && cyc < 300);
    chk("frame_done", {31'd0, mix_valid}, 32'd1);
    m  = mix;
    ms = mix_s;
    @(negedge clk);
    chk("idle_after_frame", {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dp_start"},  {31'd0, dp_start},  32'd0);
    chk({tag, "_dp_phase"},  dp_phase,           32'd0);
    chk({tag, "_mix"},       {16'd0, mix},       32'd0);
    chk({tag, "_mix_valid"}, {31'd0, mix_valid}, 32'd0);
    chk({tag, "_busy"},      {31'd0, busy},      32'd0);
    chk({tag, "_overrun"},   {31'd0, overrun},   32'd0);
  endtask

  task automatic wait_start();
    int k = 0;
    while (!dp_start && k < 50) begin @(negedge clk); k++; end
    chk("dp_start_seen", {31'd0, dp_start}, 32'd1);
  endtask

  typedef struct {
    logic [3:0]  mute;
    int          lat;
    logic [15:0] samp;
    logic [15:0] exp_mix;
    logic [15:0] exp_sat;
    int          exp_lat;
    int          exp_starts;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int cyc, s0, v0;
    logic [15:0] m, ms;

    tbl[0] = '{4'b0000, 1, 16'h4000, 16'h4000, 16'h7FFF, 18, 4};
    tbl[1] = '{4'b0000, 2, 16'h7FFF, 16'h7FFF, 16'h7FFF, 22, 4};
    tbl[2] = '{4'b0000, 1, 16'h8000, 16'h8000, 16'h8000, 18, 4};
    tbl[3] = '{4'b1111, 1, 16'h1111, 16'h0000, 16'h0000,  6, 0};
    tbl[4] = '{4'b0101, 1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 12, 2};
    tbl[5] = '{4'b1110, 4, 16'h1234, 16'h048D, 16'h1234, 12, 1};
    tbl[6] = '{4'b0000, 1, 16'hC000, 16'hC000, 16'h8000, 18, 4};

    // Reset state
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;

    // Phase sequence with echoing datapath
    inc = {32'h0000_0007, 32'h0000_2000, 32'h0000_0010, 32'h0100_0000};
    echo = 1'b1; dp_lat = 3; mute = '0;
    plog.delete();
    frame(cyc, m, ms);
    chk("echo1_lat", cyc, 32'd26);
    chk("echo1_mix", {16'd0, m}, 32'h0);
    chk("echo1_nphase", plog.size(), 32'd4);
    for (int i = 0; i < 4 && i < plog.size(); i++)
      chk($sformatf("echo1_phase%0d", i), plog[i], 32'h0);
    frame(cyc, m, ms);
    chk("echo2_nphase", plog.size(), 32'd8);
    if (plog.size() == 8) begin
      chk("echo2_phase0", plog[4], 32'h0100_0000);
      chk("echo2_phase1", plog[5], 32'h0000_0010);
      chk("echo2_phase2", plog[6], 32'h0000_2000);
      chk("echo2_phase3", plog[7], 32'h0000_0007);
    end
    chk("echo2_mix", {16'd0, m}, 32'h0040);
    chk("echo2_mix_sat", {16'd0, ms}, 32'h0100);

    // Table of mixing / saturation / latency vectors
    echo = 1'b0;
    for (int i = 0; i < 7; i++) begin
      mute = tbl[i].mute; dp_lat = tbl[i].lat; csamp = tbl[i].samp;
      s0 = nstart; v0 = nvalid;
      frame(cyc, m, ms);
      chk($sformatf("vec%0d_mix", i),    {16'd0, m},  {16'd0, tbl[i].exp_mix});
      chk($sformatf("vec%0d_sat", i),    {16'd0, ms}, {16'd0, tbl[i].exp_sat});
      chk($sformatf("vec%0d_lat", i),    cyc,         tbl[i].exp_lat);
      chk($sformatf("vec%0d_starts", i), nstart - s0, tbl[i].exp_starts);
      chk($sformatf("vec%0d_nvalid", i), nvalid - v0, 32'd1);
    end

    // Muted voice has its phase cleared; unmuting restarts it from 0
    mute = 4'b1111;
    frame(cyc, m, ms);
    mute = 4'b1011; echo = 1'b1; dp_lat = 1;
    plog.delete();
    frame(cyc, m, ms);
    chk("unmute_nphase", plog.size(), 32'd1);
    if (plog.size() > 0) chk("unmute_phase", plog[0], 32'h0);

    // Stray dp_done while idle is ignored
    @(negedge clk); stray_done = 1'b1;
    @(negedge clk); stray_done = 1'b0;
    chk("stray_busy", {31'd0, busy}, 32'd0);
    chk("stray_valid", {31'd0, mix_valid}, 32'd0);

    // Phase wrap-around
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    inc[31:0] = 32'hFFFF_FFF0; mute = 4'b1110;
    plog.delete();
    frame(cyc, m, ms);
    inc[31:0] = 32'h0000_0020;
    frame(cyc, m, ms);
    frame(cyc, m, ms);
    chk("wrap_nphase", plog.size(), 32'd3);
    if (plog.size() == 3) begin
      chk("wrap_phase1", plog[1], 32'hFFFF_FFF0);
      chk("wrap_phase2", plog[2], 32'h0000_0010);
    end

    // Tick during WAIT: dropped, overrun sticky, one mix_valid
    mute = '0; dp_lat = 3; echo = 1'b0; csamp = 16'h0100;
    v0 = nvalid;
    chk("ovr_pre", {31'd0, overrun}, 32'd0);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    wait_start();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    cyc = 0;
    while (!mix_valid && cyc < 300) begin @(negedge clk); cyc++; end
    chk("ovr_mix", {16'd0, mix}, 32'h0100);
    repeat (40) @(negedge clk);
    chk("ovr_nvalid", nvalid - v0, 32'd1);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);
    chk("ovr_idle", {31'd0, busy}, 32'd0);

    // Reset during WAIT abandons the frame; late dp_done ignored
    v0 = nvalid; s0 = nstart;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    wait_start();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk_reset("rst_wait");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_wait_busy", {31'd0, busy}, 32'd0);
    chk("rst_wait_nvalid", nvalid - v0, 32'd0);
    chk("rst_wait_starts", nstart - s0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
